// File: rtl/seg7_pkg.sv
// seg7_pkg: shared types and active-low glyph constants for the scan driver.
// Segment order is {g,f,e,d,c,b,a}; a 0 bit lights the segment.
package seg7_pkg;

    typedef logic [6:0] seg7_t;

    localparam seg7_t SEG_BLANK = 7'h7F;

    localparam seg7_t SEG_0 = 7'b1000000;
    localparam seg7_t SEG_1 = 7'b1111001;
    localparam seg7_t SEG_2 = 7'b0100100;
    localparam seg7_t SEG_3 = 7'b0110000;
    localparam seg7_t SEG_4 = 7'b0011001;
    localparam seg7_t SEG_5 = 7'b0010010;
    localparam seg7_t SEG_6 = 7'b0000010;
    localparam seg7_t SEG_7 = 7'b1111000;
    localparam seg7_t SEG_8 = 7'b0000000;
    localparam seg7_t SEG_9 = 7'b0011000;
    localparam seg7_t SEG_A = 7'b0001000;
    localparam seg7_t SEG_B = 7'b0000011;
    localparam seg7_t SEG_C = 7'b1000110;
    localparam seg7_t SEG_D = 7'b0100001;
    localparam seg7_t SEG_E = 7'b0000110;
    localparam seg7_t SEG_F = 7'b0001110;

endpackage

// File: rtl/seg7_hex_decode.sv
// seg7_hex_decode: combinational nibble -> active-low glyph.
// Ports: nibble (4b in), glyph (seg7_t out). HEX=0 blanks nibbles 10..15.
module seg7_hex_decode
    import seg7_pkg::*;
#(
    parameter int HEX = 1
) (
    input  logic [3:0] nibble,
    output seg7_t      glyph
);

    always_comb begin
        glyph = SEG_BLANK;
        case (nibble)
            4'h0: glyph = SEG_0;
            4'h1: glyph = SEG_1;
            4'h2: glyph = SEG_2;
            4'h3: glyph = SEG_3;
            4'h4: glyph = SEG_4;
            4'h5: glyph = SEG_5;
            4'h6: glyph = SEG_6;
            4'h7: glyph = SEG_7;
            4'h8: glyph = SEG_8;
            4'h9: glyph = SEG_9;
            4'hA: glyph = (HEX != 0) ? SEG_A : SEG_BLANK;
            4'hB: glyph = (HEX != 0) ? SEG_B : SEG_BLANK;
            4'hC: glyph = (HEX != 0) ? SEG_C : SEG_BLANK;
            4'hD: glyph = (HEX != 0) ? SEG_D : SEG_BLANK;
            4'hE: glyph = (HEX != 0) ? SEG_E : SEG_BLANK;
            4'hF: glyph = (HEX != 0) ? SEG_F : SEG_BLANK;
            default: glyph = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/seg7_scan_driver.sv
// seg7_scan_driver: multiplexed common-anode 7-segment driver with a
// frame-aligned shadow buffer. Ports: clk, reset (sync, active-high),
// load/value_in/dp_in/en_in (update strobe + data), busy, frame_start,
// an (active-low one-hot), seg {g..a} and dp (active-low).
// Optional macro SEG7_LZ_BLANK_EN enables leading-zero blanking.
module seg7_scan_driver
    import seg7_pkg::*;
#(
    parameter int DIGITS      = 4,
    parameter int REFRESH_DIV = 50000,
    parameter int HEX         = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  load,
    input  logic [4*DIGITS-1:0]   value_in,
    input  logic [DIGITS-1:0]     dp_in,
    input  logic [DIGITS-1:0]     en_in,
    output logic                  busy,
    output logic                  frame_start,
    output logic [DIGITS-1:0]     an,
    output seg7_t                 seg,
    output logic                  dp
);

    localparam int CW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(REFRESH_DIV - 1);
    localparam logic [IW-1:0] IDX_LAST = IW'(DIGITS - 1);

    logic [CW-1:0]       cnt;
    logic [IW-1:0]       idx;
    logic                wrap;
    logic                boundary;

    logic [4*DIGITS-1:0] act_val;
    logic [4*DIGITS-1:0] pend_val;
    logic [DIGITS-1:0]   act_dp;
    logic [DIGITS-1:0]   pend_dp;
    logic [DIGITS-1:0]   act_en;
    logic [DIGITS-1:0]   pend_en;

    logic [DIGITS-1:0]   lz;
    logic [DIGITS-1:0]   an_next;
    logic [3:0]          cur_nib;
    logic                cur_en;
    logic                cur_dp;
    logic                cur_lz;
    seg7_t               cur_glyph;

    assign wrap     = (cnt == CNT_LAST);
    assign boundary = wrap && (idx == IDX_LAST);

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt <= '0;
            idx <= '0;
        end else if (wrap) begin
            cnt <= '0;
            idx <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

    // A load coinciding with the boundary bypasses pending so it is
    // visible in the frame that is just starting.
    always_ff @(posedge clk) begin
        if (reset) begin
            act_val  <= '0;
            act_dp   <= '0;
            act_en   <= '0;
            pend_val <= '0;
            pend_dp  <= '0;
            pend_en  <= '0;
            busy     <= 1'b0;
        end else begin
            if (load) begin
                pend_val <= value_in;
                pend_dp  <= dp_in;
                pend_en  <= en_in;
            end
            if (boundary) begin
                if (load) begin
                    act_val <= value_in;
                    act_dp  <= dp_in;
                    act_en  <= en_in;
                end else if (busy) begin
                    act_val <= pend_val;
                    act_dp  <= pend_dp;
                    act_en  <= pend_en;
                end
                busy <= 1'b0;
            end else if (load) begin
                busy <= 1'b1;
            end
        end
    end

`ifdef SEG7_LZ_BLANK_EN
    logic higher_zero;

    // Walk from the most significant digit down; a disabled digit
    // counts as zero for the digits below it.
    always_comb begin
        lz          = '0;
        higher_zero = 1'b1;
        for (int i = DIGITS - 1; i >= 0; i--) begin
            if (i > 0 && act_en[i] && act_val[4*i +: 4] == 4'h0 &&
                higher_zero) begin
                lz[i] = 1'b1;
            end
            higher_zero = higher_zero &&
                (act_val[4*i +: 4] == 4'h0 || !act_en[i]);
        end
    end
`else
    assign lz = '0;
`endif

    always_comb begin
        cur_nib = 4'h0;
        cur_en  = 1'b0;
        cur_dp  = 1'b0;
        cur_lz  = 1'b0;
        an_next = '1;
        for (int i = 0; i < DIGITS; i++) begin
            if (idx == IW'(i)) begin
                cur_nib    = act_val[4*i +: 4];
                cur_en     = act_en[i];
                cur_dp     = act_dp[i];
                cur_lz     = lz[i];
                an_next[i] = 1'b0;
            end
        end
    end

    seg7_hex_decode #(
        .HEX (HEX)
    ) u_dec (
        .nibble (cur_nib),
        .glyph  (cur_glyph)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            an          <= '1;
            seg         <= SEG_BLANK;
            dp          <= 1'b1;
            frame_start <= 1'b0;
        end else begin
            an          <= an_next;
            seg         <= (cur_en && !cur_lz) ? cur_glyph : SEG_BLANK;
            dp          <= ~(cur_en & cur_dp);
            frame_start <= boundary;
        end
    end

endmodule

// File: tb/tb_seg7_scan_driver.sv
// tb_seg7_scan_driver: scoreboard bench for seg7_scan_driver (DIGITS=4,
// REFRESH_DIV=4), with HEX=1 and HEX=0 instances driven in parallel.
module tb_seg7_scan_driver;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        load = 1'b0;
    logic [15:0] value_in = 16'h0;
    logic [3:0]  dp_in = 4'h0;
    logic [3:0]  en_in = 4'h0;

    logic        busy, frame_start, dp;
    logic [3:0]  an;
    logic [6:0]  seg;
    logic        busy_h0, fs_h0, dp_h0;
    logic [3:0]  an_h0;
    logic [6:0]  seg_h0;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic [3:0][6:0] s1;
        logic [3:0][6:0] s0;
        logic [3:0]      d;
    } exp_t;

    exp_t q[$];

    localparam logic [6:0] GL [16] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
        7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
        7'b0000000, 7'b0011000, 7'b0001000, 7'b0000011,
        7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
    };

    seg7_scan_driver #(.DIGITS(4), .REFRESH_DIV(4), .HEX(1)) dut (
        .clk(clk), .reset(reset), .load(load), .value_in(value_in),
        .dp_in(dp_in), .en_in(en_in), .busy(busy),
        .frame_start(frame_start), .an(an), .seg(seg), .dp(dp)
    );

    seg7_scan_driver #(.DIGITS(4), .REFRESH_DIV(4), .HEX(0)) dut_h0 (
        .clk(clk), .reset(reset), .load(load), .value_in(value_in),
        .dp_in(dp_in), .en_in(en_in), .busy(busy_h0),
        .frame_start(fs_h0), .an(an_h0), .seg(seg_h0), .dp(dp_h0)
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog actual timeout required finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual %h required %h", name, act, exp);
        end
    endtask

    function automatic logic [6:0] glyph(input logic [3:0] n, input bit hex);
        if (!hex && n > 4'd9) return 7'h7F;
        return GL[n];
    endfunction

    task automatic push_exp(input logic [15:0] v, input logic [3:0] d,
                            input logic [3:0] e);
        exp_t x;
        logic hz;
        logic blank;
        logic [3:0] n;
        hz = 1'b1;
        for (int i = 3; i >= 0; i--) begin
            n = v[4*i +: 4];
            blank = 1'b0;
`ifdef SEG7_LZ_BLANK_EN
            blank = (i > 0) && e[i] && (n == 4'h0) && hz;
`endif
            hz = hz && (n == 4'h0 || !e[i]);
            x.s1[i] = (e[i] && !blank) ? glyph(n, 1'b1) : 7'h7F;
            x.s0[i] = (e[i] && !blank) ? glyph(n, 1'b0) : 7'h7F;
            x.d[i]  = ~(e[i] & d[i]);
        end
        q.push_back(x);
    endtask

    initial begin : monitor
        exp_t e;
        logic [3:0] ea;
        forever begin
            @(negedge clk);
            if (frame_start && q.size() > 0) begin
                e = q.pop_front();
                repeat (2) @(negedge clk);
                for (int d = 0; d < 4; d++) begin
                    if (d > 0) repeat (4) @(negedge clk);
                    ea = ~(4'b0001 << d);
                    chk($sformatf("an_d%0d", d), 32'(an), 32'(ea));
                    chk($sformatf("seg_d%0d", d), 32'(seg), 32'(e.s1[d]));
                    chk($sformatf("dp_d%0d", d), 32'(dp), 32'(e.d[d]));
                    chk($sformatf("an_h0_d%0d", d), 32'(an_h0), 32'(ea));
                    chk($sformatf("seg_h0_d%0d", d), 32'(seg_h0),
                        32'(e.s0[d]));
                    chk($sformatf("dp_h0_d%0d", d), 32'(dp_h0),
                        32'(e.d[d]));
                end
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_fs();
        int k;
        k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (!frame_start && k < 40);
        if (!frame_start) chk("frame_start_timeout", 32'(frame_start), 32'd1);
    endtask

    task automatic do_load(input logic [15:0] v, input logic [3:0] d,
                           input logic [3:0] e);
        load = 1'b1;
        value_in = v;
        dp_in = d;
        en_in = e;
        @(negedge clk);
        load = 1'b0;
        value_in = ~v;
        dp_in = ~d;
        en_in = ~e;
    endtask

    task automatic run_frame(input logic [15:0] v, input logic [3:0] d,
                             input logic [3:0] e);
        tick(3);
        push_exp(v, d, e);
        do_load(v, d, e);
        chk("busy_set", 32'(busy), 32'd1);
        wait_fs();
        chk("busy_clear", 32'(busy), 32'd0);
        wait_fs();
    endtask

    initial begin : stim
        logic [3:0] ea;
        reset = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("rst_an", 32'(an), 32'hF);
            chk("rst_seg", 32'(seg), 32'h7F);
            chk("rst_dp", 32'(dp), 32'd1);
            chk("rst_busy", 32'(busy), 32'd0);
            chk("rst_fs", 32'(frame_start), 32'd0);
        end
        reset = 1'b0;
        for (int k = 1; k <= 16; k++) begin
            @(negedge clk);
            ea = ~(4'b0001 << ((k - 1) / 4));
            chk("scan_an", 32'(an), 32'(ea));
            chk("scan_seg", 32'(seg), 32'h7F);
            chk("scan_fs", 32'(frame_start), 32'(k == 16));
        end

        run_frame(16'h12AF, 4'b0100, 4'hF);
        run_frame(16'h00C9, 4'b0000, 4'hF);

        tick(3);
        do_load(16'h1111, 4'h0, 4'hF);
        chk("busy_first", 32'(busy), 32'd1);
        tick(2);
        push_exp(16'h2222, 4'h0, 4'hF);
        do_load(16'h2222, 4'h0, 4'hF);
        chk("busy_second", 32'(busy), 32'd1);
        wait_fs();
        chk("busy_after_two", 32'(busy), 32'd0);
        wait_fs();

        tick(15);
        push_exp(16'h3456, 4'b0010, 4'hF);
        do_load(16'h3456, 4'b0010, 4'hF);
        chk("bnd_fs", 32'(frame_start), 32'd1);
        chk("bnd_busy", 32'(busy), 32'd0);
        wait_fs();

        run_frame(16'h4321, 4'b0100, 4'b1011);
        run_frame(16'h0050, 4'b0001, 4'hF);
        run_frame(16'h0000, 4'b0000, 4'hF);

        tick(3);
        do_load(16'h9876, 4'hF, 4'hF);
        chk("busy_pre_rst", 32'(busy), 32'd1);
        tick(2);
        reset = 1'b1;
        @(negedge clk);
        chk("mrst_busy", 32'(busy), 32'd0);
        chk("mrst_an", 32'(an), 32'hF);
        chk("mrst_seg", 32'(seg), 32'h7F);
        chk("mrst_dp", 32'(dp), 32'd1);
        reset = 1'b0;
        push_exp(16'h0000, 4'h0, 4'h0);
        wait_fs();
        chk("mrst_busy_fs", 32'(busy), 32'd0);
        wait_fs();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/seg7_scan_driver.md
Name: seg7_scan_driver

Overview:
- Time-multiplexed driver for DIGITS common-anode 7-segment digits, sharing one active-low segment bus.
- Replaces the single-digit BCD decode with:
  - parametrised digit count,
  - optional hex glyphs,
  - per-digit enable and decimal point,
  - a shadow-buffered load handshake that applies new values only at frame boundaries, so the display never tears.
- Sits between the lab datapath (counters, SPI-received data) and the board display pins.

Parameters:
- DIGITS, 4: number of multiplexed digits, 1..8.
- REFRESH_DIV, 50000: clk cycles each digit is lit; must be >= 2.
- HEX, 1: 1 = nibbles 10..15 show A,b,C,d,E,F; 0 = nibbles 10..15 are blank (legacy decimal behaviour).

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- load  in  1  one-cycle strobe; captures value_in/dp_in/en_in into the pending buffer
- value_in  in  4*DIGITS  nibble i = value_in[4i+3:4i]; digit 0 is rightmost
- dp_in  in  DIGITS  decimal point request per digit, 1 = lit
- en_in  in  DIGITS  per-digit enable, 0 = digit blank (segments and dp off)
- busy  out  1  1 while a pending update awaits a frame boundary
- frame_start  out  1  one-cycle pulse when the scan wraps to digit 0
- an  out  DIGITS  anode selects, active-low, one-hot-low
- seg  out  7  {g,f,e,d,c,b,a}, active-low
- dp  out  1  decimal point, active-low

Behaviour:
- Reset (synchronous, highest priority) sets:
  - an = all 1s, seg = 7'h7F, dp = 1, busy = 0, frame_start = 0;
  - refresh counter = 0, digit index = 0;
  - active and pending buffers = 0, en = 0.
  - Reset asserted mid-operation discards any pending load.
- Refresh counter:
  - counts 0..REFRESH_DIV-1, then wraps to 0.
  - On the wrap cycle, index advances by 1, wrapping DIGITS-1 -> 0.
  - DIGITS = 1: index stays 0 and every counter wrap is a frame boundary.
- Frame boundary = cycle on which index goes DIGITS-1 -> 0. frame_start is registered high for exactly the next cycle.
- Outputs are registered and lag index by one cycle:
  - an[i] = 0 only for i == index;
  - seg = glyph(active nibble[index]);
  - dp = ~active_dp[index].
  - If active_en[index] = 0: seg = 7'h7F and dp = 1, but the anode is still driven low.
- Glyphs (active-low):
  - 0 1000000, 1 1111001, 2 0100100, 3 0110000, 4 0011001
  - 5 0010010, 6 0000010, 7 1111000, 8 0000000, 9 0011000
  - A 0001000, b 0000011, C 1000110, d 0100001, E 0000110, F 0001110
  - With HEX = 0, nibbles 10..15 give 1111111.
- Load handshake:
  - load = 1 copies the inputs into pending and sets busy.
  - A second load while busy overwrites pending (last wins).
  - At a frame boundary with busy = 1, active <= pending and busy clears.
  - The new value is first seen on digit 0 of the new frame.
- Simultaneous load and frame boundary: the load data goes straight to active and busy stays/clears to 0; the older pending data is dropped.
- Inputs are ignored when load = 0. No combinational input-to-output path.

Optional Feature:
- Macro: SEG7_LZ_BLANK_EN.
- Defined: leading-zero blanking. Any enabled digit i > 0 whose nibble is 0, with every higher digit either zero or disabled, shows 7'h7F. Digit 0 is never blanked; its dp still follows dp_in.
- Undefined: zeros always render as "0".

Decomposition:
- Package seg7_pkg holds:
  - typedef seg7_t (logic [6:0]);
  - constants SEG_BLANK = 7'h7F and the 16 glyph constants;
  - function-free table usage.
- Sub-module seg7_hex_decode (combinational, parameter HEX): nibble -> seg7_t, instantiated once on the muxed nibble.

Test Plan:
1. Reset behaviour: DIGITS=4, REFRESH_DIV=4; hold reset 3 cycles, then release -> while in reset an=1111, seg=7F, dp=1; after release an cycles 1110,1101,1011,0111, 4 cycles each; frame_start pulses every 16 cycles.
2. Load then scan: load value_in=16'h12AF, en=4'hF, dp=4'b0100 -> busy=1 until frame_start. Next frame shows:
   - digit0 = 0001110 (F);
   - digit1 = 0001000 (A);
   - digit2 = 0100100 (2), dp=0;
   - digit3 = 1111001 (1).
3. HEX=0 with value 16'h00C9 -> digit1 = 7F, digit0 = 0011000.
4. Load collisions: two loads mid-frame (16'h1111, then 16'h2222) -> only 2222 is ever displayed. A load on the frame-boundary cycle -> its value appears immediately in the next frame, busy=0.
5. Disabled digit and mid-frame reset: en_in=4'b1011 -> digit2 seg=7F, dp=1, an[2]=0 in its slot. Reset asserted mid-frame with busy=1 -> busy=0 and all buffers cleared.
6. SEG7_LZ_BLANK_EN defined, value 16'h0050 -> digits 3,2 blank, digit1 "5", digit0 "0". Value 16'h0000 -> only digit0 shows "0".
